// File: rtl/sram_pkg.sv
// ============================================================================
//  Module   : sram_pkg
//  Purpose  : Shared types and constants for the parametrised SRAM controller.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package sram_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int MAX_DATA_W = 1024;
    localparam logic [MAX_DATA_W-1:0] FILL_WORD = '0;

    function automatic int byte_lanes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_array.sv
// ============================================================================
//  Module   : sram_array
//  Purpose  : Single-port storage, byte-enable write, registered read, no reset.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sram_array
    import sram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int BE_W   = byte_lanes(DATA_W)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/param_sram_ctrl.sv
// ============================================================================
//  Module   : param_sram_ctrl
//  Purpose  : Valid/ready SRAM front end with zero-fill sweep and range check.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module param_sram_ctrl
    import sram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int BE_W   = byte_lanes(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [BE_W-1:0]   req_be,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              err,
    output logic              init_done
);

    // One extra bit keeps DEPTH and DEPTH-1 representable when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_X  = (ADDR_W+1)'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   clr_addr_q, clr_addr_d;
    logic              rd_valid_q, rd_valid_d;
    logic              err_q, err_d;
    logic              rd_zero_q, rd_zero_d;

    logic              accept;
    logic              in_range;
    logic              mem_we;
    logic              mem_re;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    always_comb begin
        req_ready = (state_q == READY) && !clear_req;
        accept    = req_valid && req_ready;
        in_range  = {1'b0, req_addr} < DEPTH_X;

        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == CLEAR) begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == LAST_X) begin
                state_d    = READY;
                clr_addr_d = '0;
            end
        end else if (clear_req) begin
            state_d    = CLEAR;
            clr_addr_d = '0;
        end

        rd_valid_d = accept && !req_we;
        err_d      = accept && !in_range;
        // rd_data masks the array output after an out-of-range read until the next read.
        rd_zero_d  = (accept && !req_we) ? !in_range : rd_zero_q;

        if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_be    = '1;
            mem_addr  = clr_addr_q[ADDR_W-1:0];
            mem_wdata = FILL_WORD[DATA_W-1:0];
        end else begin
            mem_we    = accept && req_we && in_range;
            mem_be    = req_be;
            mem_addr  = req_addr;
            mem_wdata = req_wdata;
        end
        mem_re = accept && !req_we && in_range;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            rd_zero_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
            rd_zero_q  <= rd_zero_d;
        end
    end

    sram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .BE_W   (BE_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .be    (mem_be),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign rd_valid  = rd_valid_q;
    assign err       = err_q;
    assign init_done = (state_q == READY);
    assign rd_data   = rd_zero_q ? '0 : mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_param_sram_ctrl.sv
// ============================================================================
//  Module   : tb_param_sram_ctrl
//  Purpose  : Scoreboard bench for param_sram_ctrl (DATA_W=32, ADDR_W=4, DEPTH=12).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_param_sram_ctrl;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int DP = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          clear_req = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [3:0]    req_be = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          err;
    logic          init_done;

    typedef struct {
        logic          rv;
        logic          er;
        logic [DW-1:0] d;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] model [DP];
    int            n_checks = 0;
    int            n_pass = 0;
    int            cyc = 0;
    int            last_rv_cyc = -10;
    int            prev_rv_cyc = -20;

    param_sram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear_req (clear_req),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_be    (req_be),
        .req_wdata (req_wdata),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .err       (err),
        .init_done (init_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, wanted 0x%08h", name, act, exp);
    endtask

    // Monitor: every response-bearing cycle is matched against the scoreboard head.
    always @(negedge clk) begin
        if (reset && (rd_valid || err)) begin
            if (rd_valid) begin
                prev_rv_cyc = last_rv_cyc;
                last_rv_cyc = cyc;
            end
            if (sb_q.size() == 0) begin
                check("unexpected_response", {30'd0, rd_valid, err}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("resp_rd_valid", {31'd0, rd_valid}, {31'd0, e.rv});
                check("resp_err", {31'd0, err}, {31'd0, e.er});
                if (e.rv) check("resp_rd_data", rd_data, e.d);
            end
        end
    end

    function automatic void model_clear();
        for (int i = 0; i < DP; i++) model[i] = '0;
    endfunction

    // Reference behaviour of one accepted request.
    function automatic void model_accept(input logic we, input int addr, input logic [3:0] be,
                                         input logic [DW-1:0] wd);
        exp_t e;
        if (addr >= DP) begin
            e.rv = !we; e.er = 1'b1; e.d = '0;
            sb_q.push_back(e);
        end else if (we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) model[addr][8*b +: 8] = wd[8*b +: 8];
        end else begin
            e.rv = 1'b1; e.er = 1'b0; e.d = model[addr];
            sb_q.push_back(e);
        end
    endfunction

    task automatic issue(input logic we, input int addr, input logic [3:0] be,
                         input logic [DW-1:0] wd, input bit with_clear);
        int n;
        int low;
        req_valid = 1'b1; req_we = we; req_addr = AW'(addr); req_be = be; req_wdata = wd;
        clear_req = with_clear;
        if (with_clear) begin
            @(negedge clk);
            check("collision_req_ready", {31'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
            clear_req = 1'b0;
            model_clear();
            low = 0;
            while (!init_done && low < 40) begin
                low++;
                @(posedge clk); #1;
            end
            check("clear_low_cycles", low, 12);
        end
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        check("accept_timeout", {31'd0, n >= 50}, 32'd0);
        if (n < 50) model_accept(we, addr, be, wd);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_init(input string name);
        int k;
        k = 0;
        while (!init_done && k < 40) begin
            k++;
            @(posedge clk); #1;
        end
        check(name, k, 12);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_init_done", {31'd0, init_done}, 32'd0);
        check("reset_req_ready", {31'd0, req_ready}, 32'd0);
        check("reset_rd_data", rd_data, 32'd0);

        @(posedge clk); #1;
        reset = 1'b1;
        model_clear();
        wait_init("init_latency");
        check("ready_idle", {31'd0, req_ready}, 32'd1);

        for (int a = 0; a < DP; a++) issue(1'b0, a, 4'h0, '0, 1'b0);

        // Byte-enable merge
        issue(1'b1, 3, 4'b1111, 32'hDEADBEEF, 1'b0);
        issue(1'b1, 3, 4'b0101, 32'h11223344, 1'b0);
        issue(1'b0, 3, 4'h0, '0, 1'b0);
        idle(2);
        check("be_merge_model", model[3], 32'hDE22BE44);

        // Back-to-back reads
        issue(1'b1, 5, 4'hF, 32'hA5A5A5A5, 1'b0);
        issue(1'b1, 7, 4'hF, 32'h0F0F0F0F, 1'b0);
        issue(1'b0, 5, 4'h0, '0, 1'b0);
        issue(1'b0, 7, 4'h0, '0, 1'b0);
        idle(2);
        check("b2b_consecutive", last_rv_cyc - prev_rv_cyc, 1);

        // Out-of-range and a neighbouring in-range word
        issue(1'b1, 12, 4'hF, 32'hFFFFFFFF, 1'b0);
        issue(1'b0, 13, 4'h0, '0, 1'b0);
        issue(1'b0, 11, 4'h0, '0, 1'b0);
        issue(1'b1, 15, 4'h0, 32'h1, 1'b0);
        issue(1'b1, 4, 4'h0, 32'hCAFEF00D, 1'b0);
        issue(1'b0, 4, 4'h0, '0, 1'b0);

        // Soft clear colliding with a held read
        issue(1'b1, 2, 4'hF, 32'h12345678, 1'b0);
        issue(1'b0, 2, 4'h0, '0, 1'b1);
        idle(2);

        // Randomised traffic
        for (int i = 0; i < 80; i++) begin
            issue(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), $urandom, 1'b0);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(3);
        check("sb_drained", sb_q.size(), 0);

        // Reset in the middle of a soft clear
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        model_clear();
        idle(5);
        reset = 1'b0;
        #1;
        check("midreset_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("midreset_err", {31'd0, err}, 32'd0);
        check("midreset_init_done", {31'd0, init_done}, 32'd0);
        idle(2);
        reset = 1'b1;
        wait_init("reinit_latency");
        issue(1'b0, 6, 4'h0, '0, 1'b0);
        issue(1'b0, 14, 4'h0, '0, 1'b0);
        idle(3);
        check("sb_final_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, wanted finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
